// File: rtl/ceres_pbus_bridge.sv
// rtl/ceres_pbus_bridge.sv - iomem request to APB4-style peripheral transfer bridge
// Optional ACCESS-phase timeout is compiled in when PBUS_TIMEOUT_EN is defined.
module ceres_pbus_bridge #(
  parameter int LINE_W         = 128,
  parameter int NUM_SLOTS      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  input  logic                    req_sel_i,
  input  logic [31:0]             req_addr_i,
  input  logic [LINE_W-1:0]       req_wdata_i,
  input  logic [LINE_W/8-1:0]     req_rw_i,
  output logic                    res_valid_o,
  output logic [LINE_W-1:0]       res_data_o,
  output logic                    res_err_o,
  output logic                    busy_o,
  output logic [NUM_SLOTS-1:0]    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [11:0]             paddr_o,
  output logic [31:0]             pwdata_o,
  output logic [3:0]              pstrb_o,
  input  logic [NUM_SLOTS*32-1:0] prdata_i,
  input  logic [NUM_SLOTS-1:0]    pready_i,
  input  logic [NUM_SLOTS-1:0]    pslverr_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;
  localparam int LANES = LINE_W / 32;

  logic [1:0]  state_q;
  logic [3:0]  slot_q;
  logic [11:0] paddr_q;
  logic [31:0] pwdata_q;
  logic [3:0]  pstrb_q;
  logic        pwrite_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] lane_wdata;
  logic [3:0]  lane_strb;
  logic [31:0] sel_prdata;
  logic        sel_pready;
  logic        sel_pslverr;
  logic        unmapped;
  logic        unused_bits;

  assign unmapped    = int'(req_addr_i[15:12]) >= NUM_SLOTS;
  assign unused_bits = ^{req_addr_i[31:16], req_addr_i[1:0]};

  // Pick the 32-bit lane of the cache line addressed by addr[3:2]
  always_comb begin
    lane_wdata = '0;
    lane_strb  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (req_addr_i[3:2] == 2'(i)) begin
        lane_wdata = req_wdata_i[i*32 +: 32];
        lane_strb  = req_rw_i[i*4 +: 4];
      end
    end
  end

  // Only the latched slot's handshake is observed; other slots are ignored
  always_comb begin
    psel_o      = '0;
    sel_prdata  = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q == 4'(i)) begin
        psel_o[i]   = (state_q == S_SETUP) || (state_q == S_ACCESS);
        sel_prdata  = prdata_i[i*32 +: 32];
        sel_pready  = pready_i[i];
        sel_pslverr = pslverr_i[i];
      end
    end
  end

`ifdef PBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_q;
  logic             tmo_expired;

  assign tmo_expired = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Held at zero in IDLE so it starts clean on every SETUP entry
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == S_IDLE) begin
      tmo_q <= '0;
    end else if (state_q == S_ACCESS && !sel_pready && !tmo_expired) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_sel_i) begin
            slot_q   <= req_addr_i[15:12];
            paddr_q  <= req_addr_i[11:0];
            pwdata_q <= lane_wdata;
            pstrb_q  <= lane_strb;
            pwrite_q <= |req_rw_i;
            rdata_q  <= '0;
            err_q    <= unmapped;
            state_q  <= unmapped ? S_RESP : S_SETUP;
          end
        end
        S_SETUP: state_q <= S_ACCESS;
        S_ACCESS: begin
          if (sel_pready) begin
            rdata_q <= pwrite_q ? 32'h0 : sel_prdata;
            err_q   <= sel_pslverr;
            state_q <= S_RESP;
          end
`ifdef PBUS_TIMEOUT_EN
          else if (tmo_expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end
`endif
        end
        S_RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // rdata_q/err_q are only non-zero while in RESP
  assign res_valid_o = (state_q == S_RESP);
  assign res_data_o  = LINE_W'(rdata_q);
  assign res_err_o   = err_q;
  assign busy_o      = (state_q != S_IDLE);
  assign penable_o   = (state_q == S_ACCESS);
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;

endmodule

// File: tb/tb_ceres_pbus_bridge.sv
// tb/tb_ceres_pbus_bridge.sv - randomized self-checking bench for ceres_pbus_bridge
// Build with PBUS_TIMEOUT_EN defined to exercise the timeout path.
module tb_ceres_pbus_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_sel;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_rw;
  logic         res_valid, res_err, busy, penable, pwrite;
  logic [127:0] res_data;
  logic [7:0]   psel;
  logic [11:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [255:0] prdata;
  logic [7:0]   pready, pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  int           o_lat;
  logic [127:0] o_data;
  logic         o_err, o_pen1, o_pwrite, o_apb, o_stable, o_leak;
  logic [7:0]   o_psel;
  logic [11:0]  o_paddr;
  logic [31:0]  o_pwdata;
  logic [3:0]   o_pstrb;
  logic [3:0]   o_after;

  ceres_pbus_bridge #(.LINE_W(128), .NUM_SLOTS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_sel_i(req_sel), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rw_i(req_rw),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_err_o(res_err), .busy_o(busy),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .pstrb_o(pstrb),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  // Slave model: the addressed slot withholds pready for 'waits' access cycles;
  // every other slot shows random handshake noise.
  task automatic drive_slave(input int slot, input int acc, input int waits,
                             input logic [31:0] rdval, input logic slverr);
    for (int i = 0; i < 8; i++) prdata[i*32 +: 32] = $urandom;
    pready  = 8'($urandom);
    pslverr = 8'($urandom);
    if (slot < 8) begin
      prdata[slot*32 +: 32] = rdval;
      pslverr[slot] = slverr;
      pready[slot]  = penable && psel[slot] && (acc == waits);
    end
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic [127:0] wdata, input logic [15:0] rw,
                        input int waits, input logic [31:0] rdval, input logic slverr, input int budget);
    int acc;
    int slot;
    acc = 0;
    slot = int'(addr[15:12]);
    o_lat = -1; o_data = '0; o_err = 1'b0; o_psel = '0; o_pen1 = 1'b0; o_paddr = '0;
    o_pwdata = '0; o_pstrb = '0; o_pwrite = 1'b0; o_apb = 1'b0; o_stable = 1'b1;
    o_leak = 1'b0; o_after = '0;
    @(negedge clk);
    req_valid = 1'b1; req_sel = 1'b1; req_addr = addr; req_wdata = wdata; req_rw = rw;
    drive_slave(slot, acc, waits, rdval, slverr);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin
        o_psel = psel; o_pen1 = penable; o_paddr = paddr;
        o_pwdata = pwdata; o_pstrb = pstrb; o_pwrite = pwrite;
      end
      if (slot >= 8 && psel != 8'h0) o_apb = 1'b1;
      if (penable && {paddr, pwdata, pstrb, pwrite} != {o_paddr, o_pwdata, o_pstrb, o_pwrite})
        o_stable = 1'b0;
      if (res_valid) begin
        o_lat = k; o_data = res_data; o_err = res_err;
        req_valid = 1'b0; req_sel = 1'b0; pready = '0;
        @(negedge clk);
        o_after = {res_valid, busy, |res_data, res_err};
        break;
      end
      if (res_data != '0 || res_err) o_leak = 1'b1;
      req_addr = $urandom; req_wdata = {4{$urandom}}; req_rw = 16'($urandom);
      drive_slave(slot, acc, waits, rdval, slverr);
      if (penable) acc++;
    end
    req_valid = 1'b0; req_sel = 1'b0; pready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0; req_addr = '0; req_wdata = '0; req_rw = '0;
    prdata = '0; pready = '0; pslverr = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({res_valid, res_data, res_err, busy, psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b busy=%b psel=%h pen=%b paddr=%h pwdata=%h, want all 0",
               res_valid, busy, psel, penable, paddr, pwdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    // Zero-wait read from slot 1
    do_txn(32'h2000_1008, '0, 16'h0, 0, 32'hA5A5_1234, 1'b0, 50);
    n_cmp++;
    if (o_lat !== 3 || o_data !== 128'hA5A5_1234 || o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL read_slot1: lat=%0d data=%h err=%b, want lat=3 data=a5a51234 err=0", o_lat, o_data, o_err);
    end
    n_cmp++;
    if (o_psel !== 8'h02 || o_paddr !== 12'h008 || o_pwrite !== 1'b0) begin
      n_bad++;
      $display("FAIL read_slot1_apb: psel=%h paddr=%h pwrite=%b, want 02 008 0", o_psel, o_paddr, o_pwrite);
    end
    // Write to slot 4, lane 3, two wait states
    do_txn(32'h2000_400C, {32'hCAFE_F00D, 96'h0}, 16'hF000, 2, 32'h1111_2222, 1'b0, 50);
    n_cmp++;
    if (o_lat !== 5 || o_data !== '0 || o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL write_slot4: lat=%0d data=%h err=%b, want lat=5 data=0 err=0", o_lat, o_data, o_err);
    end
    n_cmp++;
    if (o_pwrite !== 1'b1 || o_pstrb !== 4'hF || o_pwdata !== 32'hCAFE_F00D || o_psel !== 8'h10) begin
      n_bad++;
      $display("FAIL write_slot4_apb: pwrite=%b pstrb=%h pwdata=%h psel=%h, want 1 f cafef00d 10",
               o_pwrite, o_pstrb, o_pwdata, o_psel);
    end
    // Unmapped slot 9
    do_txn(32'h2000_9000, '0, 16'h0, 0, 32'hDEAD_BEEF, 1'b0, 50);
    n_cmp++;
    if (o_lat !== 1 || o_err !== 1'b1 || o_data !== '0 || o_apb !== 1'b0) begin
      n_bad++;
      $display("FAIL unmapped: lat=%0d err=%b data=%h apb=%b, want lat=1 err=1 data=0 apb=0",
               o_lat, o_err, o_data, o_apb);
    end
    // Slave error on slot 2, confined to the response cycle
    do_txn(32'h2000_2010, '0, 16'h0, 1, 32'h0BAD_0BAD, 1'b1, 50);
    n_cmp++;
    if (o_lat !== 4 || o_err !== 1'b1 || o_after !== 4'b0000) begin
      n_bad++;
      $display("FAIL slverr: lat=%0d err=%b after=%b, want lat=4 err=1 after=0000", o_lat, o_err, o_after);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [31:0]  addr, rdval, e_pwdata, e_data;
      logic [127:0] wdata;
      logic [15:0]  rw;
      logic [3:0]   e_pstrb;
      logic         slverr, mapped, e_err;
      int           waits, slot, lane, e_lat;
      slot   = $urandom_range(0, 9);
      addr   = {16'h2000, 4'(slot), 12'($urandom)};
      wdata  = {$urandom, $urandom, $urandom, $urandom};
      rw     = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      waits  = $urandom_range(0, 3);
      rdval  = $urandom;
      slverr = ($urandom_range(0, 3) == 0);
      // Reference: arithmetic on the request, independent of DUT internals
      mapped   = slot < 8;
      lane     = int'(addr[3:2]);
      e_pwdata = 32'(wdata >> (32 * lane));
      e_pstrb  = 4'(rw >> (4 * lane));
      e_lat    = mapped ? 3 + waits : 1;
      e_data   = (mapped && rw == 16'h0) ? rdval : 32'h0;
      e_err    = mapped ? slverr : 1'b1;
      do_txn(addr, wdata, rw, waits, rdval, slverr, 50);
      n_cmp++;
      if (o_lat !== e_lat || o_data !== 128'(e_data) || o_err !== e_err) begin
        n_bad++;
        $display("FAIL rand_resp[%0d]: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                 t, o_lat, o_data, o_err, e_lat, e_data, e_err);
      end
      n_cmp++;
      if (o_after !== 4'b0000 || o_leak !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_pulse[%0d]: after=%b leak=%b, want 0000 0", t, o_after, o_leak);
      end
      n_cmp++;
      if (mapped) begin
        if ({o_psel, o_pen1, o_paddr, o_pwdata, o_pstrb, o_pwrite, o_stable} !==
            {8'(1 << slot), 1'b0, addr[11:0], e_pwdata, e_pstrb, rw != 16'h0, 1'b1}) begin
          n_bad++;
          $display("FAIL rand_apb[%0d]: psel=%h pen=%b paddr=%h pwdata=%h pstrb=%h pwrite=%b stable=%b, want %h 0 %h %h %h %b 1",
                   t, o_psel, o_pen1, o_paddr, o_pwdata, o_pstrb, o_pwrite, o_stable,
                   8'(1 << slot), addr[11:0], e_pwdata, e_pstrb, rw != 16'h0);
        end
      end else if (o_apb !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_unmapped_apb[%0d]: apb=%b, want 0", t, o_apb);
      end
    end
  endtask

  task automatic test_no_sel();
    @(negedge clk);
    req_valid = 1'b1; req_sel = 1'b0; req_addr = 32'h2000_1000; req_rw = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || psel !== 8'h0 || res_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL no_sel[%0d]: busy=%b psel=%h valid=%b, want 0 00 0", k, busy, psel, res_valid);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    @(negedge clk);
    req_valid = 1'b1; req_sel = 1'b1; req_addr = 32'h2000_0004; req_rw = '0; req_wdata = '0;
    prdata = '0; prdata[31:0] = 32'h1357_9BDF; pready = 8'hFF; pslverr = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (res_valid) begin
        pulses.push_back(k);
        n_cmp++;
        if (res_data !== 128'h1357_9BDF || res_err !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_data[%0d]: data=%h err=%b, want 13579bdf 0", k, res_data, res_err);
        end
      end
    end
    req_valid = 1'b0; req_sel = 1'b0; pready = '0;
    n_cmp++;
    if (pulses.size() != 2 || pulses[0] != 3 || pulses[1] != 7) begin
      n_bad++;
      $display("FAIL b2b_timing: pulses=%0d first=%0d second=%0d, want 2 3 7", pulses.size(),
               pulses.size() > 0 ? pulses[0] : -1, pulses.size() > 1 ? pulses[1] : -1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int late;
    late = 0;
    @(negedge clk);
    req_valid = 1'b1; req_sel = 1'b1; req_addr = 32'h2000_5004; req_rw = 16'h00F0;
    req_wdata = {4{32'h5A5A_5A5A}}; pready = '0; pslverr = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (penable !== 1'b1 || psel !== 8'h20) begin
      n_bad++;
      $display("FAIL mid_access: pen=%b psel=%h, want 1 20", penable, psel);
    end
    rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, psel, penable, res_valid, pwrite, paddr, pwdata, pstrb} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: busy=%b psel=%h pen=%b valid=%b pwrite=%b paddr=%h, want all 0",
               busy, psel, penable, res_valid, pwrite, paddr);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (res_valid) late++;
    end
    n_cmp++;
    if (late != 0) begin
      n_bad++;
      $display("FAIL mid_reset_pulse: pulses=%0d, want 0", late);
    end
    do_txn(32'h2000_6000, '0, 16'h0, 1, 32'h7777_0001, 1'b0, 50);
    n_cmp++;
    if (o_lat !== 4 || o_data !== 128'h7777_0001 || o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_read: lat=%0d data=%h err=%b, want 4 77770001 0", o_lat, o_data, o_err);
    end
  endtask

  task automatic test_timeout();
`ifdef PBUS_TIMEOUT_EN
    do_txn(32'h2000_3000, '0, 16'h0, 100000, 32'h4242_4242, 1'b0, 100);
    n_cmp++;
    if (o_lat !== 18 || o_err !== 1'b1 || o_data !== '0) begin
      n_bad++;
      $display("FAIL timeout: lat=%0d err=%b data=%h, want 18 1 0", o_lat, o_err, o_data);
    end
`else
    do_txn(32'h2000_3000, '0, 16'h0, 100000, 32'h4242_4242, 1'b0, 1000);
    n_cmp++;
    if (o_lat !== -1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL no_timeout: lat=%0d busy=%b, want -1 1", o_lat, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_no_sel();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
